alu_issue_stage: RTL
====================

# alu_issue_stage

Registered issue stage that turns one decoded RV32I instruction into the ALU's 4-bit `Operation` code and its `SrcA`/`SrcB` operands. It sits between register-file read and the ALU, on the producing side of the ALU's operation/operand interface. A valid/ready handshake with a one-entry skid buffer gives full throughput, registered backpressure and single-cycle flush.

## Interface
- `DATA_WIDTH`, 32, operand width
- `OPCODE_LENGTH`, 4, ALU operation code width
- `clk` in 1: sole clock, rising edge
- `reset` in 1: asynchronous, active-high
- `in_valid` in 1: upstream instruction valid
- `in_ready` out 1: stage can accept
- `in_instr` in 32: raw instruction
- `in_rs1_data` in DATA_WIDTH: rs1 value
- `in_rs2_data` in DATA_WIDTH: rs2 value
- `in_imm` in DATA_WIDTH: immediate, already sign-extended upstream
- `flush` in 1: discard all held and incoming work
- `out_valid` out 1: issued op valid
- `out_ready` in 1: ALU/EX stage consumes
- `out_src_a`, `out_src_b` out DATA_WIDTH: ALU operands
- `out_operation` out OPCODE_LENGTH: ALU code
- `out_rd` out 5: destination register
- `out_is_branch` out 1: branch compare op
- `out_br_invert` out 1: branch taken when ALU result == 0
- `out_illegal` out 1: unsupported encoding

## Operation
- ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0011, SLL 0100, SRL 0101, SRA 0111, EQ 1000, XOR 1001, PASSB 1010, SLT 1100.
- The decode key is opcode = `instr[6:0]`, funct3 = `[14:12]`, funct7 = `[31:25]`. SrcA is rs1 unless stated otherwise.
- **R-type (0110011), SrcB = rs2:**
  - 000/0000000 ADD; 000/0100000 SUB
  - 111 AND; 110 OR; 100 XOR; 010 SLT
  - 001/0000000 SLL; 101/0000000 SRL; 101/0100000 SRA
- **I-ALU (0010011), SrcB = imm:** same funct3 map without SUB. Shifts check funct7 exactly as R-type.
- **Load (0000011), store (0100011), JALR (1100111):** ADD, SrcB = imm.
- **LUI (0110111):** PASSB, SrcA = 0, SrcB = imm.
- **Branch (1100011):** SrcB = rs2, `is_branch` = 1.
  - 000 EQ, invert = 0
  - 001 EQ, invert = 1
  - 100 SLT, invert = 0
  - 101 SLT, invert = 1
- **Anything else:** ADD, operands as R-type, `illegal` = 1. The packet still flows; the trap is handled downstream.
- `out_rd` = `instr[11:7]`. It is forced to 0 for branch and store.
- **Storage:** output register (OR) and skid register (SK), each with a valid bit.
  - `in_ready` = !SK.valid, driven straight from a flop.
- **Per-edge rules, priority order:**
  1. `flush` clears OR.valid and SK.valid. An input accepted that cycle is dropped.
  2. If OR empty, or `out_valid && out_ready`: OR loads from SK if SK valid; otherwise from the accepted input, if any.
  3. If an input is accepted while OR is held (valid && !out_ready), it goes to SK.
  4. If OR is refilled from SK and an input is accepted the same cycle, the input goes to SK.
- Ordering is strictly FIFO. There is no combinational path from `out_ready` to `in_ready`.

## Timing
- Latency: input accepted at edge N → `out_valid` = 1 after edge N, with decoded fields.
- Throughput: one per cycle with `out_ready` held high.
- **Reset (async assert, sync release):**
  - `out_valid` = 0; OR.valid = SK.valid = 0
  - `in_ready` = 1
  - all data outputs = 0, and `out_operation` = 0000
- Outputs hold their value while `out_valid && !out_ready`. Data while `out_valid` = 0 holds the last value.
- Backpressure: `in_ready` falls the cycle after SK fills. It rises the cycle after SK drains.
- Flush and reset mid-stream: no partial packet ever appears. SK contents never surface after a flush.

## Structure
- Package `alu_issue_pkg`:
  - opcode localparams
  - `alu_op_e` enum with the ALU codes above
  - funct3/funct7 constants
  - `issue_pkt_t` struct (src_a, src_b, operation, rd, is_branch, br_invert, illegal)
- Sub-module `alu_op_decode`: purely combinational, instr/rs1/rs2/imm → `issue_pkt_t`.
- `alu_issue_stage` instantiates it and owns OR/SK and the handshake.

## Test plan
- SUB x3,x1,x2 `0x402081B3`, rs1=10, rs2=3, out_ready=1 → next cycle: out_valid=1, operation 0011, src_a=10, src_b=3, rd=3.
- ADDI x1,x0,-1 `0xFFF00093`, imm=`0xFFFFFFFF`, then SRAI x1,x1,2 `0x4020D093`, imm=2, back-to-back → consecutive outputs: 0010/src_b=`0xFFFFFFFF`, then 0111/src_b=2. `in_ready` stays 1.
- BNE x1,x2,8 `0x00209463` → operation 1000, is_branch=1, br_invert=1, rd=0, src_b=rs2.
- Hold out_ready=0 and send A, B, C → in_ready drops after B; C is held upstream. Release → A, B, C issue in order on three cycles, with no loss or duplicate.
- Fill OR and SK, then flush while also presenting D → next cycle out_valid=0 and in_ready=1; D never appears. Assert reset mid-stream → outputs zero immediately (asynchronous).
- Instruction `0xFFFFFFFF` → illegal=1, operation 0010, handshake unaffected.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared decode constants, ALU operation codes and the issue packet
// produced by alu_op_decode and held by alu_issue_stage.
package alu_issue_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SUB   = 4'b0011,
    ALU_SLL   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_SRA   = 4'b0111,
    ALU_EQ    = 4'b1000,
    ALU_XOR   = 4'b1001,
    ALU_PASSB = 4'b1010,
    ALU_SLT   = 4'b1100
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    alu_op_e         operation;
    logic [4:0]      rd;
    logic            is_branch;
    logic            br_invert;
    logic            illegal;
  } issue_pkt_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I decode: raw instruction plus operands into an issue packet.
module alu_op_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] imm_i,
  output issue_pkt_t      pkt_o
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       bad;
  logic       unused_instr_bits;

  assign opcode            = instr_i[6:0];
  assign funct3            = instr_i[14:12];
  assign funct7            = instr_i[31:25];
  assign unused_instr_bits = ^instr_i[24:15];

  always_comb begin
    pkt_o           = '0;
    pkt_o.src_a     = rs1_data_i;
    pkt_o.src_b     = rs2_data_i;
    pkt_o.operation = ALU_ADD;
    pkt_o.rd        = instr_i[11:7];
    bad             = 1'b0;
    case (opcode)
      OPC_R, OPC_I: begin
        if (opcode == OPC_I) pkt_o.src_b = imm_i;
        case (funct3)
          F3_ADD: begin
            if (opcode == OPC_R && funct7 == F7_ALT) pkt_o.operation = ALU_SUB;
            else if (opcode == OPC_R && funct7 != F7_BASE) bad = 1'b1;
          end
          F3_AND: pkt_o.operation = ALU_AND;
          F3_OR:  pkt_o.operation = ALU_OR;
          F3_XOR: pkt_o.operation = ALU_XOR;
          F3_SLT: pkt_o.operation = ALU_SLT;
          F3_SLL: begin
            if (funct7 == F7_BASE) pkt_o.operation = ALU_SLL;
            else bad = 1'b1;
          end
          F3_SR: begin
            if (funct7 == F7_BASE) pkt_o.operation = ALU_SRL;
            else if (funct7 == F7_ALT) pkt_o.operation = ALU_SRA;
            else bad = 1'b1;
          end
          default: bad = 1'b1;
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_JALR: begin
        pkt_o.src_b = imm_i;
        if (opcode == OPC_STORE) pkt_o.rd = 5'd0;
      end
      OPC_LUI: begin
        pkt_o.src_a     = '0;
        pkt_o.src_b     = imm_i;
        pkt_o.operation = ALU_PASSB;
      end
      OPC_BRANCH: begin
        pkt_o.is_branch = 1'b1;
        pkt_o.rd        = 5'd0;
        case (funct3)
          F3_BEQ: pkt_o.operation = ALU_EQ;
          F3_BNE: begin pkt_o.operation = ALU_EQ;  pkt_o.br_invert = 1'b1; end
          F3_BLT: pkt_o.operation = ALU_SLT;
          F3_BGE: begin pkt_o.operation = ALU_SLT; pkt_o.br_invert = 1'b1; end
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
    // Unsupported encodings still flow as a plain R-type ADD, tagged for a downstream trap.
    if (bad) begin
      pkt_o.src_a     = rs1_data_i;
      pkt_o.src_b     = rs2_data_i;
      pkt_o.operation = ALU_ADD;
      pkt_o.rd        = instr_i[11:7];
      pkt_o.is_branch = 1'b0;
      pkt_o.br_invert = 1'b0;
      pkt_o.illegal   = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Registered ALU issue stage: decode into an output register backed by a
// one-entry skid register, so in_ready is a flop and never sees out_ready.
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [DATA_WIDTH-1:0]    in_rs1_data,
  input  logic [DATA_WIDTH-1:0]    in_rs2_data,
  input  logic [DATA_WIDTH-1:0]    in_imm,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_src_a,
  output logic [DATA_WIDTH-1:0]    out_src_b,
  output logic [OPCODE_LENGTH-1:0] out_operation,
  output logic [4:0]               out_rd,
  output logic                     out_is_branch,
  output logic                     out_br_invert,
  output logic                     out_illegal
);

  issue_pkt_t dec_pkt;
  issue_pkt_t or_q, or_d, sk_q, sk_d;
  logic       or_vld_q, or_vld_d, sk_vld_q, sk_vld_d;
  logic       in_ready_q;
  logic       accept, or_free;

  alu_op_decode u_decode (
    .instr_i    (in_instr),
    .rs1_data_i (in_rs1_data),
    .rs2_data_i (in_rs2_data),
    .imm_i      (in_imm),
    .pkt_o      (dec_pkt)
  );

  assign accept  = in_valid && in_ready_q;
  assign or_free = !or_vld_q || out_ready;

  always_comb begin
    or_d     = or_q;
    sk_d     = sk_q;
    or_vld_d = or_vld_q;
    sk_vld_d = sk_vld_q;
    if (flush) begin
      or_vld_d = 1'b0;
      sk_vld_d = 1'b0;
    end else if (or_free) begin
      if (sk_vld_q) begin
        or_d     = sk_q;
        or_vld_d = 1'b1;
        sk_d     = accept ? dec_pkt : sk_q;
        sk_vld_d = accept;
      end else begin
        if (accept) or_d = dec_pkt;
        or_vld_d = accept;
      end
    end else if (accept) begin
      sk_d     = dec_pkt;
      sk_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      or_q       <= '0;
      sk_q       <= '0;
      or_vld_q   <= 1'b0;
      sk_vld_q   <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      or_q       <= or_d;
      sk_q       <= sk_d;
      or_vld_q   <= or_vld_d;
      sk_vld_q   <= sk_vld_d;
      in_ready_q <= !sk_vld_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = or_vld_q;
  assign out_src_a     = or_q.src_a;
  assign out_src_b     = or_q.src_b;
  assign out_operation = or_q.operation;
  assign out_rd        = or_q.rd;
  assign out_is_branch = or_q.is_branch;
  assign out_br_invert = or_q.br_invert;
  assign out_illegal   = or_q.illegal;

endmodule
